// File: rtl/maxpool_pkg.sv
// Shared constants and state encoding for the 7x7 max-pool result collector.
package maxpool_pkg;
  localparam int DATA_W       = 8;
  localparam int POOL_IN_DIM  = 14;
  localparam int POOL_OUT_DIM = 7;
  localparam int NUM_WIN      = POOL_OUT_DIM * POOL_OUT_DIM;
  localparam int IDX_W        = 6;
  localparam int LAST_IDX     = NUM_WIN - 1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
endpackage

// File: rtl/maxpool7x7_collector.sv
// Walks the 49 pooling windows, captures each pooled pixel into a flat 7x7 map, then holds it for the consumer.
// Optional MAXPOOL_COLLECT_PIPE_EN registers pool_out before capture (one extra drain cycle in SCAN).
module maxpool7x7_collector
  import maxpool_pkg::*;
#(
  parameter int DATA_W  = maxpool_pkg::DATA_W,
  parameter int OUT_DIM = maxpool_pkg::POOL_OUT_DIM,
  parameter int NUM_WIN = OUT_DIM * OUT_DIM,
  parameter int IDX_W   = maxpool_pkg::IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [IDX_W-1:0]          pool_idx,
  input  logic [DATA_W-1:0]         pool_out,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W*NUM_WIN-1:0] pic_out,
  output logic                      pic_valid,
  input  logic                      pic_ack
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WIN - 1);

  state_t state;

`ifdef MAXPOOL_COLLECT_PIPE_EN
  logic [DATA_W-1:0] pool_q;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_vld;
  logic              drain;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pool_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pic_valid <= 1'b0;
      pic_out   <= '0;
`ifdef MAXPOOL_COLLECT_PIPE_EN
      pool_q    <= '0;
      wr_idx    <= '0;
      wr_vld    <= 1'b0;
      drain     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MAXPOOL_COLLECT_PIPE_EN
      // Write stage trails the index by one cycle; the drain cycle issues no new sample.
      pool_q <= pool_out;
      wr_idx <= pool_idx;
      wr_vld <= (state == SCAN) && !drain;
      if (wr_vld) pic_out[DATA_W*int'(wr_idx) +: DATA_W] <= pool_q;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
`ifdef MAXPOOL_COLLECT_PIPE_EN
          if (drain) begin
            drain     <= 1'b0;
            state     <= HOLD;
            pool_idx  <= '0;
            busy      <= 1'b0;
            pic_valid <= 1'b1;
            done      <= 1'b1;
          end else if (pool_idx == LAST) begin
            drain <= 1'b1;
          end else begin
            pool_idx <= pool_idx + 1'b1;
          end
`else
          pic_out[DATA_W*int'(pool_idx) +: DATA_W] <= pool_out;
          if (pool_idx == LAST) begin
            state     <= HOLD;
            pool_idx  <= '0;
            busy      <= 1'b0;
            pic_valid <= 1'b1;
            done      <= 1'b1;
          end else begin
            pool_idx <= pool_idx + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (pic_ack) begin
            pic_valid <= 1'b0;
            if (start) begin
              state <= SCAN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
